// File: rtl/if_fetch_if.sv
// IF-stage bundle: byte-wide memory read port, IF/ID presentation, stall vector and EX redirect.
// The fetch unit takes the master side of this bundle.
interface if_fetch_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [4:0]        stall;
  logic              br_en;
  logic [31:0]       br_target;
  logic              mem_gnt;
  logic [7:0]        mem_din;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       if_pc;
  logic [31:0]       if_inst;
  logic              stall_req;

  modport master (
    input  stall, br_en, br_target, mem_gnt, mem_din,
    output mem_rd, mem_addr, if_pc, if_inst, stall_req
  );

  modport slave (
    output stall, br_en, br_target, mem_gnt, mem_din,
    input  mem_rd, mem_addr, if_pc, if_inst, stall_req
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: assembles a 32-bit instruction from four little-endian byte reads and holds
// it for the IF/ID register until consumed or redirected.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rdy_i,
  if_fetch_if.master    bus
);

  typedef enum logic [0:0] {StIssue, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  issue_idx_q, issue_idx_d;
  logic [1:0]  cap_idx_q, cap_idx_d;
  logic [23:0] buf_q, buf_d;
  logic        inflight_q, inflight_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        stall_req_q, stall_req_d;

  logic        issuing;
  logic [31:0] addr_full;
  logic        unused_stall;

  assign issuing   = (state_q == StIssue) && !issue_idx_q[2];
  assign addr_full = pc_q + {29'b0, issue_idx_q};

  // Gated by rst_ni so the read port is quiet while reset is held.
  assign bus.mem_rd    = rst_ni & rdy_i & issuing;
  assign bus.mem_addr  = rst_ni ? addr_full[ADDR_W-1:0] : '0;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.stall_req = stall_req_q;

  assign unused_stall = ^bus.stall[4:1];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issue_idx_d = issue_idx_q;
    cap_idx_d   = cap_idx_q;
    buf_d       = buf_q;
    inflight_d  = inflight_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    stall_req_d = stall_req_q;

    if (rdy_i) begin
      if (bus.br_en) begin
        // Redirect wins over consume and over a completing capture; in-flight data is dropped.
        pc_d        = bus.br_target;
        issue_idx_d = '0;
        cap_idx_d   = '0;
        inflight_d  = 1'b0;
        state_d     = StIssue;
        stall_req_d = 1'b1;
        if_pc_d     = '0;
        if_inst_d   = '0;
      end else begin
        case (state_q)
          StIssue: begin
            inflight_d = issuing && bus.mem_gnt;
            if (issuing && bus.mem_gnt) begin
              issue_idx_d = issue_idx_q + 3'd1;
            end
            if (inflight_q) begin
              if (cap_idx_q == 2'd3) begin
                if_inst_d   = {bus.mem_din, buf_q};
                if_pc_d     = pc_q;
                stall_req_d = 1'b0;
                cap_idx_d   = '0;
                state_d     = StHold;
              end else begin
                cap_idx_d = cap_idx_q + 2'd1;
                case (cap_idx_q)
                  2'd0:    buf_d[7:0]   = bus.mem_din;
                  2'd1:    buf_d[15:8]  = bus.mem_din;
                  2'd2:    buf_d[23:16] = bus.mem_din;
                  default: buf_d        = buf_q;
                endcase
              end
            end
          end
          StHold: begin
            if (!bus.stall[0]) begin
              pc_d        = pc_q + 32'd4;
              issue_idx_d = '0;
              cap_idx_d   = '0;
              state_d     = StIssue;
              stall_req_d = 1'b1;
            end
          end
          default: state_d = StIssue;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIssue;
      pc_q        <= RESET_PC;
      issue_idx_q <= '0;
      cap_idx_q   <= '0;
      buf_q       <= '0;
      inflight_q  <= 1'b0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
      stall_req_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issue_idx_q <= issue_idx_d;
      cap_idx_q   <= cap_idx_d;
      buf_q       <= buf_d;
      inflight_q  <= inflight_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      stall_req_q <= stall_req_d;
    end
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage; the producer side of the IF/ID pipeline-register interface.
- Fetches each 32-bit RISC-V instruction as four little-endian bytes over a byte-wide, arbitrated memory read port.
- Presents if_pc/if_inst to the IF/ID register and raises stall_req to the stall controller until a complete instruction is held.
- Accepts branch/jump redirects from EX.

Parameters:
- RESET_PC, 32'h0000_0000, pc loaded at reset.
- ADDR_W, 32, width of mem_addr (low ADDR_W bits of the byte address).

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets immediately, independent of clk).
- rdy  in  1  global ready; when 0, all state and outputs hold.
- stall  in  5  pipeline stall vector; stall[0]==0 at a posedge means IF/ID captures if_pc/if_inst this edge.
- br_en  in  1  redirect request from EX.
- br_target  in  32  redirect address.
- mem_gnt  in  1  arbiter grant for the read port in this cycle.
- mem_din  in  8  read byte; valid one cycle after a granted request.
- mem_rd  out  1  read request.
- mem_addr  out  ADDR_W  byte address of the request.
- if_pc  out  32  pc of the presented instruction.
- if_inst  out  32  presented instruction.
- stall_req  out  1  1 = no complete instruction held.

Behaviour:
- Reset (rst==0): pc=RESET_PC, state=ISSUE, issue index=0, capture index=0, byte buffer=0, mem_rd=0, mem_addr=0, if_pc=0, if_inst=0, stall_req=1.
- rdy==0: no state or output changes; mem_rd is forced to 0 combinationally.
- State ISSUE:
  - mem_rd=1 and mem_addr=pc+issue_idx.
  - On a posedge with mem_gnt=1: mark a byte in flight and increment issue_idx.
  - mem_gnt=0: address held; nothing counted.
- Capture: on the posedge after each granted request, store mem_din into byte[cap_idx] and increment cap_idx. Byte 0 lands in bits 7:0, byte 3 in bits 31:24.
- Issue and capture overlap. With mem_gnt held at 1, requests go out on cycles 0–3 and bytes are captured on edges 1–4.
- After the 4th request is granted: mem_rd=0 and the unit waits for the last capture.
- When the 4th byte is captured: state=HOLD, if_inst={byte3,byte2,byte1,byte0}, if_pc=pc, stall_req=0 from that edge.
  - Minimum latency is 5 cycles from fetch start to stall_req=0.
- HOLD:
  - mem_rd=0; if_pc/if_inst stable.
  - Posedge with stall[0]==0: instruction consumed; pc=pc+4, indices=0, state=ISSUE, stall_req=1.
  - stall[0]==1: remain in HOLD indefinitely.
- Redirect (br_en==1 at a posedge, any state, rdy==1):
  - pc=br_target, indices=0, state=ISSUE, stall_req=1, if_inst=0, if_pc=0.
  - Any in-flight byte returning on the next edge is discarded (no capture).
  - br_en beats consume in HOLD.
  - br_en beats a simultaneous 4th-byte capture: that instruction is never presented.
- pc arithmetic is modulo 2^32. mem_addr is the low ADDR_W bits of pc+issue_idx. No alignment check; pc[1:0]!=0 fetches the 4 bytes starting at pc.
- stall_req is registered (no combinational path from inputs). mem_rd/mem_addr are combinational from state plus rdy only.
- rst asserted mid-fetch: immediate return to reset values; any pending memory response is ignored because the capture index is cleared.

Test Plan:
- Reset release, RESET_PC=0, memory bytes 0..3 = 13 05 10 00, mem_gnt=1, stall=0 -> mem_addr 0,1,2,3 on cycles 0–3; stall_req=0 on cycle 5 with if_inst=32'h00100513, if_pc=0; next cycle fetch begins at address 4.
- Same program with mem_gnt low on the 2nd request for 3 cycles -> mem_addr held at 1 during the gap; instruction presented on cycle 8, bytes not duplicated or skipped.
- Hold instruction with stall=5'b00011 for 10 cycles -> if_pc/if_inst unchanged, stall_req=0, mem_rd=0; stall=0 -> next edge stall_req=1, mem_addr=4.
- br_en=1, br_target=32'h100 on the edge the 3rd byte is captured -> stall_req stays 1, next mem_addr=32'h100, stale byte ignored; presented if_pc=32'h100 with the bytes at 0x100–0x103.
- br_en with stall[0]==0 in HOLD at pc=8 -> fetch resumes at br_target, not at 12.
- rdy=0 for 4 cycles mid-fetch, then rst pulsed low mid-fetch -> no progress while rdy=0; on rst assertion outputs return immediately to reset values; after release, fetch restarts at RESET_PC.
